// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg -- shared constants for the two-requester ALU arbiter.
//   DW_DEF / CW_DEF : default operand and control-code widths
//   ST_*            : FSM state encoding (IDLE, EXEC, RESP)
//   ALU_*           : control codes understood by the shared ALU
package alu_arb_pkg;

   localparam int DW_DEF = 32;
   localparam int CW_DEF = 4;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_EXEC = 2'b01;
   localparam logic [1:0] ST_RESP = 2'b10;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_LUI  = 4'b0101;
   localparam logic [3:0] ALU_BGEZ = 4'b1111;
   localparam logic [3:0] ALU_BNE  = 4'b1010;

endpackage

// File: rtl/alu_arb_if.sv
// alu_arb_if -- bundle of every non-clock signal of alu_arb.
//   req0_* / req1_* : operation requests (valid, operands, control) and ready
//   rsp_*           : registered result handshake (valid/ready, id, data, flags)
//   alu_*           : operands/code to the shared ALU and its combinational result
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters, consumer and shared ALU)
interface alu_arb_if
   import alu_arb_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int CW = CW_DEF
) ();

   logic          req0_valid;
   logic [DW-1:0] req0_a;
   logic [DW-1:0] req0_b;
   logic [CW-1:0] req0_ctrl;
   logic          req0_ready;

   logic          req1_valid;
   logic [DW-1:0] req1_a;
   logic [DW-1:0] req1_b;
   logic [CW-1:0] req1_ctrl;
   logic          req1_ready;

   logic          rsp_valid;
   logic          rsp_ready;
   logic          rsp_id;
   logic [DW-1:0] rsp_data;
   logic          rsp_overflow;
   logic          rsp_zero;

   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [CW-1:0] alu_control;
   logic [DW-1:0] alu_rd;
   logic          alu_overflow;
   logic          alu_zero;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_ctrl,
      input  req1_valid, req1_a, req1_b, req1_ctrl,
      input  rsp_ready,
      input  alu_rd, alu_overflow, alu_zero,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_data, rsp_overflow, rsp_zero,
      output alu_a, alu_b, alu_control
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_ctrl,
      output req1_valid, req1_a, req1_b, req1_ctrl,
      output rsp_ready,
      output alu_rd, alu_overflow, alu_zero,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_data, rsp_overflow, rsp_zero,
      input  alu_a, alu_b, alu_control
   );

endinterface

// File: rtl/alu_arb_grant.sv
// alu_arb_grant -- combinational two-way grant selection.
//   valid0, valid1 : requester n has an operation pending
//   ptr            : id of the requester granted last
//   gnt            : one-hot grant vector (bit n = requester n), 0 when idle
//   gnt_id         : index of the granted requester
// A lone requester always wins. On a conflict the requester that was not
// granted last wins; holding ptr at 1 turns this into fixed req0 priority.
module alu_arb_grant (
   input  logic       valid0,
   input  logic       valid1,
   input  logic       ptr,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   always_comb begin
      gnt    = 2'b00;
      gnt_id = 1'b0;
      if (valid0 && valid1) begin
         gnt_id = ~ptr;
      end else if (valid1) begin
         gnt_id = 1'b1;
      end
      if (valid0 || valid1) begin
         gnt = gnt_id ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/alu_arb.sv
// alu_arb -- shares one combinational ALU between two requesters.
// Ports:
//   clk   : system clock, all state updates on the rising edge
//   reset : synchronous active-high reset
//   bus   : alu_arb_if.slave (requests, response handshake, shared-ALU link)
// Flow: IDLE grants one requester and latches its operands, EXEC gives the
// external ALU one cycle and captures its result, RESP holds the result until
// the consumer takes it. One operation takes at least three cycles.
// Configuration:
//   ALU_ARB_RR_EN defined   -> round-robin on conflicts via a last-grant pointer
//   ALU_ARB_RR_EN undefined -> fixed priority, req0 wins conflicts
module alu_arb
   import alu_arb_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int CW = CW_DEF
) (
   input  logic     clk,
   input  logic     reset,
   alu_arb_if.slave bus
);

   logic [1:0]    state_q, state_d;
   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic [CW-1:0] ctrl_q, ctrl_d;
   logic          id_q, id_d;
   logic [DW-1:0] rsp_data_q, rsp_data_d;
   logic          rsp_ovf_q, rsp_ovf_d;
   logic          rsp_zero_q, rsp_zero_d;

   logic [1:0]    gnt;
   logic          gnt_id;
   logic          ptr;
   logic          accept;

   alu_arb_grant u_grant (
      .valid0 (bus.req0_valid),
      .valid1 (bus.req1_valid),
      .ptr    (ptr),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   // Grants only take effect while idle; the selector itself is free-running.
   assign accept = (state_q == ST_IDLE) && (gnt != 2'b00);

`ifdef ALU_ARB_RR_EN
   logic ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = gnt_id;
      end
   end

   // Reset value 1 sends the first conflict after reset to req0.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= 1'b1;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;
`else
   // "req1 granted last" forever, so req0 wins every conflict.
   assign ptr = 1'b1;
`endif

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      ctrl_d     = ctrl_q;
      id_d       = id_q;
      rsp_data_d = rsp_data_q;
      rsp_ovf_d  = rsp_ovf_q;
      rsp_zero_d = rsp_zero_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_EXEC;
               id_d    = gnt_id;
               a_d     = gnt_id ? bus.req1_a    : bus.req0_a;
               b_d     = gnt_id ? bus.req1_b    : bus.req0_b;
               ctrl_d  = gnt_id ? bus.req1_ctrl : bus.req0_ctrl;
            end
         end
         ST_EXEC: begin
            state_d    = ST_RESP;
            rsp_data_d = bus.alu_rd;
            rsp_ovf_d  = bus.alu_overflow;
            rsp_zero_d = bus.alu_zero;
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         ctrl_q     <= '0;
         id_q       <= 1'b0;
         rsp_data_q <= '0;
         rsp_ovf_q  <= 1'b0;
         rsp_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         ctrl_q     <= ctrl_d;
         id_q       <= id_d;
         rsp_data_q <= rsp_data_d;
         rsp_ovf_q  <= rsp_ovf_d;
         rsp_zero_q <= rsp_zero_d;
      end
   end

   assign bus.req0_ready   = accept && gnt[0];
   assign bus.req1_ready   = accept && gnt[1];

   // id_q only changes on a grant, so it is stable for the whole of RESP.
   assign bus.rsp_valid    = (state_q == ST_RESP);
   assign bus.rsp_id       = id_q;
   assign bus.rsp_data     = rsp_data_q;
   assign bus.rsp_overflow = rsp_ovf_q;
   assign bus.rsp_zero     = rsp_zero_q;

   assign bus.alu_a        = a_q;
   assign bus.alu_b        = b_q;
   assign bus.alu_control  = ctrl_q;

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb -- self-checking bench for alu_arb with a behavioural shared ALU
// and a cycle-level scoreboard of grants and responses.
module tb_alu_arb;
   import alu_arb_pkg::*;

`ifdef ALU_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] data;
      logic        ovf;
      logic        zero;
   } res_t;

   typedef struct packed {
      logic id;
      res_t res;
   } exp_t;

   typedef enum int {M_IDLE, M_EXEC, M_RESP} mstate_t;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_err    = 0;

   alu_arb_if #(.DW(32), .CW(4)) bus ();

   alu_arb #(.DW(32), .CW(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic res_t alu_model(input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] c);
      res_t        r;
      logic [32:0] s;
      r = '0;
      s = '0;
      case (c)
         ALU_AND:  r.data = a & b;
         ALU_OR:   r.data = a | b;
         ALU_ADD: begin
            s      = {1'b0, a} + {1'b0, b};
            r.data = s[31:0];
            r.ovf  = s[32];
         end
         ALU_SUB: begin
            r.data = a - b;
            r.ovf  = (a < b);
         end
         ALU_SLT:  r.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_NOR:  r.data = ~(a | b);
         ALU_LUI:  r.data = {b[15:0], 16'h0000};
         ALU_BGEZ: r.data = {31'd0, ~a[31]};
         ALU_BNE:  r.data = a ^ b;
         default:  r.data = 32'd0;
      endcase
      r.zero = (r.data == 32'd0);
      return r;
   endfunction

   // Shared ALU: combinational on the arbiter's operand outputs.
   res_t alu_out;
   assign alu_out          = alu_model(bus.alu_a, bus.alu_b, bus.alu_control);
   assign bus.alu_rd       = alu_out.data;
   assign bus.alu_overflow = alu_out.ovf;
   assign bus.alu_zero     = alu_out.zero;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model state
   exp_t    sb[$];
   logic    gnt_log[$];
   mstate_t m_state = M_IDLE;
   logic    m_last  = 1'b1;
   bit      m_en    = 1'b0;

   always @(negedge clk) begin
      logic [1:0] exp_rdy;
      logic       gid;
      res_t       r;
      exp_rdy = 2'b00;
      gid     = 1'b0;
      if (m_state == M_IDLE && (bus.req0_valid || bus.req1_valid)) begin
         if (bus.req0_valid && bus.req1_valid) gid = RR ? ~m_last : 1'b0;
         else                                  gid = bus.req1_valid;
         exp_rdy = gid ? 2'b10 : 2'b01;
      end
      if (m_en) begin
         check("ready", {bus.req1_ready, bus.req0_ready}, exp_rdy);
         check("rsp_valid", bus.rsp_valid, m_state == M_RESP);
         if (m_state == M_RESP) begin
            check("sb_depth", sb.size(), 1);
            if (sb.size() > 0) begin
               check("rsp_id", bus.rsp_id, sb[0].id);
               check("rsp_data", bus.rsp_data, sb[0].res.data);
               check("rsp_ovf", bus.rsp_overflow, sb[0].res.ovf);
               check("rsp_zero", bus.rsp_zero, sb[0].res.zero);
            end
         end
      end
      if (reset) begin
         m_state = M_IDLE;
         m_last  = 1'b1;
         sb.delete();
         m_en    = 1'b1;
      end else if (m_en) begin
         case (m_state)
            M_IDLE: if (exp_rdy != 2'b00) begin
               r = gid ? alu_model(bus.req1_a, bus.req1_b, bus.req1_ctrl)
                       : alu_model(bus.req0_a, bus.req0_b, bus.req0_ctrl);
               sb.push_back('{id: gid, res: r});
               gnt_log.push_back(gid);
               m_last  = gid;
               m_state = M_EXEC;
            end
            M_EXEC: m_state = M_RESP;
            M_RESP: if (bus.rsp_ready) begin
               void'(sb.pop_front());
               m_state = M_IDLE;
            end
            default: m_state = M_IDLE;
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Drive one request and return in the cycle after it was accepted (EXEC).
   task automatic issue(input logic k, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c);
      logic seen;
      seen = 1'b0;
      if (k) begin
         bus.req1_a = a; bus.req1_b = b; bus.req1_ctrl = c; bus.req1_valid = 1'b1;
      end else begin
         bus.req0_a = a; bus.req0_b = b; bus.req0_ctrl = c; bus.req0_valid = 1'b1;
      end
      for (int i = 0; i < 20 && !seen; i++) begin
         #1;
         seen = k ? bus.req1_ready : bus.req0_ready;
         tick();
      end
      check("issue_accepted", seen, 1'b1);
      if (k) bus.req1_valid = 1'b0;
      else   bus.req0_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 30 && !(sb.size() == 0 && m_state == M_IDLE); i++) tick();
      check("drain", sb.size(), 0);
   endtask

   logic [3:0] ops [9];
   logic       exp_order [4];

   initial begin
      ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_LUI, ALU_BGEZ, ALU_BNE};
      reset = 1'b1;
      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_ctrl = '0;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_ctrl = '0;
      bus.rsp_ready  = 1'b1;
      do_reset();

      // Reset state
      check("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check("rst_rsp_id", bus.rsp_id, 1'b0);
      check("rst_rsp_data", bus.rsp_data, 32'd0);
      check("rst_alu_a", bus.alu_a, 32'd0);
      check("rst_alu_b", bus.alu_b, 32'd0);
      check("rst_alu_ctrl", bus.alu_control, 4'd0);

      // Single req0 ADD 5+7 with explicit latency
      bus.req0_a = 32'd5; bus.req0_b = 32'd7; bus.req0_ctrl = ALU_ADD; bus.req0_valid = 1'b1;
      #1;
      check("add_ready_n", bus.req0_ready, 1'b1);
      tick();
      bus.req0_valid = 1'b0;
      #1;
      check("add_ready_n1", bus.req0_ready, 1'b0);
      check("add_valid_n1", bus.rsp_valid, 1'b0);
      tick();
      check("add_valid_n2", bus.rsp_valid, 1'b1);
      check("add_id", bus.rsp_id, 1'b0);
      check("add_data", bus.rsp_data, 32'd12);
      check("add_zero", bus.rsp_zero, 1'b0);
      check("add_ovf", bus.rsp_overflow, 1'b0);
      wait_idle();

      // req1 SUB 9-9 -> zero
      issue(1'b1, 32'd9, 32'd9, ALU_SUB);
      tick();
      check("sub_data", bus.rsp_data, 32'd0);
      check("sub_zero", bus.rsp_zero, 1'b1);
      check("sub_id", bus.rsp_id, 1'b1);
      wait_idle();

      // req0 ADD FFFFFFFF+1 -> overflow from ALU
      issue(1'b0, 32'hFFFF_FFFF, 32'd1, ALU_ADD);
      tick();
      check("ovf_flag", bus.rsp_overflow, 1'b1);
      check("ovf_data", bus.rsp_data, 32'd0);
      wait_idle();

      // Mixed single-requester operations
      for (int i = 0; i < 8; i++) begin
         issue(1'($urandom_range(0, 1)), $urandom, $urandom, ops[$urandom_range(0, 8)]);
         wait_idle();
      end

      // Continuous conflict for four grants
      do_reset();
      gnt_log.delete();
      bus.req0_a = 32'd3;  bus.req0_b = 32'd4; bus.req0_ctrl = ALU_ADD;
      bus.req1_a = 32'd10; bus.req1_b = 32'd2; bus.req1_ctrl = ALU_SUB;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      for (int i = 0; i < 40 && gnt_log.size() < 4; i++) tick();
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      check("conflict_grants", gnt_log.size(), 4);
      exp_order = RR ? '{1'b0, 1'b1, 1'b0, 1'b1} : '{1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         if (i < gnt_log.size()) check($sformatf("grant_order%0d", i), gnt_log[i], exp_order[i]);
      end
      wait_idle();

      // Backpressure in RESP with req1 waiting
      bus.rsp_ready = 1'b0;
      issue(1'b0, 32'h0000_00F0, 32'h0000_0F0F, ALU_OR);
      bus.req1_a = 32'd1; bus.req1_b = 32'd2; bus.req1_ctrl = ALU_SLT; bus.req1_valid = 1'b1;
      #1;
      check("bp_exec_ready1", bus.req1_ready, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_ready1", bus.req1_ready, 1'b0);
         check("bp_valid", bus.rsp_valid, 1'b1);
         check("bp_data", bus.rsp_data, 32'h0000_0FFF);
         if (i < 4) tick();
      end
      bus.rsp_ready = 1'b1;
      tick();
      check("bp_release_ready1", bus.req1_ready, 1'b1);
      tick();
      bus.req1_valid = 1'b0;
      wait_idle();

      // Reset while a response is pending
      bus.rsp_ready = 1'b0;
      issue(1'b1, 32'h1234, 32'h55, ALU_OR);
      tick();
      check("mid_valid_before", bus.rsp_valid, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rsp_valid", bus.rsp_valid, 1'b0);
      check("mid_alu_a", bus.alu_a, 32'd0);
      check("mid_alu_b", bus.alu_b, 32'd0);
      check("mid_alu_ctrl", bus.alu_control, 4'd0);
      check("mid_rsp_data", bus.rsp_data, 32'd0);
      bus.rsp_ready = 1'b1;
      tick();
      tick();
      check("mid_no_rsp", bus.rsp_valid, 1'b0);
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter: DW, 32, operand/result width.
REQ-002 Parameter: CW, 4, ALU control-code width.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid/req1_valid  input  1  requester n has an operation pending.
REQ-006 req0_a/req1_a, req0_b/req1_b  input  DW  operands A and B of requester n.
REQ-007 req0_ctrl/req1_ctrl  input  CW  ALU control code of requester n.
REQ-008 req0_ready/req1_ready  output  1  requester n's operation accepted this cycle.
REQ-009 rsp_valid  output  1  result available; rsp_ready  input  1  consumer takes it.
REQ-010 rsp_id  output  1  index of the requester owning the result.
REQ-011 rsp_data  output  DW; rsp_overflow, rsp_zero  output  1  registered ALU result and flags.
REQ-012 alu_a, alu_b  output  DW; alu_control  output  CW  operands/code driven to the shared ALU.
REQ-013 alu_rd  input  DW; alu_overflow, alu_zero  input  1  combinational ALU result and flags.

Function
REQ-014 FSM states IDLE, EXEC, RESP; exactly one active.
REQ-015 IDLE: if any req_valid, grant one requester, assert its req_ready combinationally for that cycle only, latch its a/b/ctrl and id, go to EXEC; else stay IDLE.
REQ-016 req_ready SHALL be 0 outside IDLE and 0 for the non-granted requester.
REQ-017 alu_a/alu_b/alu_control SHALL be driven from the latched operand registers at all times.
REQ-018 EXEC: one cycle; at its end latch alu_rd, alu_overflow, alu_zero into rsp registers, go to RESP.
REQ-019 RESP: rsp_valid=1; rsp_id/rsp_data/flags held stable until rsp_valid && rsp_ready, then go to IDLE.
REQ-020 Latency: accept at cycle N -> rsp_valid first high at N+2; minimum 3 cycles per operation.
REQ-021 Single requester valid: that requester is granted regardless of history.
REQ-022 Both valid: grant per arbitration policy (REQ-026); loser keeps req_valid and is served next.
REQ-023 New req_valid during EXEC/RESP is not accepted until return to IDLE.
REQ-024 Result data/flags are passed unmodified from ALU inputs; no width change, no recomputation.

Reset
REQ-025 reset high at a clock edge: state=IDLE, operand/ctrl registers=0, rsp registers=0, rsp_valid=0, rsp_id=0, last-grant pointer=1; applies mid-operation, discarding any in-flight operation without a response.

Configuration
REQ-026 Macro ALU_ARB_RR_EN: defined -> round-robin; on conflict grant the requester not granted last; pointer updates only on a grant; first conflict after reset goes to req0.
REQ-027 ALU_ARB_RR_EN undefined -> fixed priority, req0 always wins conflicts; no pointer register exists.

Structure
REQ-028 Package alu_arb_pkg SHALL hold: state encoding (IDLE, EXEC, RESP), DW/CW defaults, ALU control constants AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100, LUI=0101, BGEZ=1111, BNE=1010.
REQ-029 Grant logic SHALL be one sub-module alu_arb_grant (inputs: two valids, pointer; outputs: grant vector, grant id); the shared ALU stays outside this block.

Verification
REQ-030 Reset mid-RESP (rsp_valid=1) -> next cycle rsp_valid=0, state IDLE, alu_a/alu_b/alu_control=0.
REQ-031 req0 only, a=5, b=7, ctrl=ADD, ALU model returns 12 -> req0_ready 1 cycle, rsp_valid 2 cycles later, rsp_id=0, rsp_data=12, zero=0, overflow=0.
REQ-032 req1 SUB a=9 b=9 -> rsp_data=0, rsp_zero=1, rsp_id=1.
REQ-033 req0 ADD a=FFFFFFFF b=1, ALU model overflow=1 -> rsp_overflow=1, rsp_data passed as given.
REQ-034 Both valid continuously for 4 ops -> with ALU_ARB_RR_EN grant order 0,1,0,1; without it 0,0,0,0.
REQ-035 rsp_ready held 0 for 5 cycles in RESP with req1_valid=1 -> rsp outputs stable, req1_ready stays 0; release -> IDLE next cycle, req1 granted.
